wait_state_data_memory: RTL and testbench



---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 30 +++
 rtl/wait_state_data_memory.sv | 143 ++++++++++++++
 tb/tb_wait_state_data_memory.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data memory: FSM encoding,
// wait-counter width and word/byte geometry.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int CNT_W   = 4;   // holds LATENCY-1 for LATENCY up to 15
  localparam int WORD_W  = 32;
  localparam int BYTE_W  = 8;
  localparam int BYTES_W = WORD_W / BYTE_W;

endpackage

// File: rtl/dmem_array.sv
// Backing word array: synchronous write with per-byte mask, combinational read.
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [BYTES_W-1:0] wbe,
  output logic [WORD_W-1:0]  rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-masked write; disabled lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES_W; i++) begin
        if (wbe[i]) mem[addr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/wait_state_data_memory.sv
// Data-memory responder with req/ready/resp handshake and LATENCY wait states.
// Optional feature: define DMEM_BYTE_EN_EN to add the be[3:0] byte-enable input.
module wait_state_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] wd,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]        be,
`endif
  output logic              ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] rd,
  output logic              err
);

  dmem_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  a_q, a_d;
  logic [WORD_W-1:0]  wd_q, wd_d;
  logic               we_q, we_d;
  logic [WORD_W-1:0]  rd_q, rd_d;
  logic               err_q, err_d;
  logic [BYTES_W-1:0] wbe;
  logic [WORD_W-1:0]  mem_rdata;
  logic               accept, commit, addr_err, mem_we;

`ifdef DMEM_BYTE_EN_EN
  logic [BYTES_W-1:0] be_q, be_d;
  assign wbe = be_q;
`else
  assign wbe = '1;
`endif

  assign accept   = req && ready;
  assign commit   = (state_q == WAIT) && (cnt_q == '0);
  // Decoded from the latched address so late input changes cannot matter.
  assign addr_err = (a_q[1:0] != 2'b00) || (a_q >= WORD_W'(DEPTH * BYTES_W));
  assign mem_we   = commit && we_q && !addr_err;

  dmem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (a_q[ADDR_W+1:2]),
    .wdata (wd_q),
    .wbe   (wbe),
    .rdata (mem_rdata)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE/RESP accept, WAIT runs until the counter expires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = req ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; RESP doubles as an accept slot.
  always_comb begin
    ready      = 1'b1;
    resp_valid = 1'b0;
    case (state_q)
      WAIT:    ready = 1'b0;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: request latch, wait counter, response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      a_q   <= '0;
      we_q  <= 1'b0;
      wd_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
      be_q  <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      we_q  <= we_d;
      wd_q  <= wd_d;
      rd_q  <= rd_d;
      err_q <= err_d;
`ifdef DMEM_BYTE_EN_EN
      be_q  <= be_d;
`endif
    end
  end

  // Latch on accept, count down in WAIT, resolve rd/err at the commit edge.
  always_comb begin
    a_d   = a_q;
    we_d  = we_q;
    wd_d  = wd_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    err_d = err_q;
`ifdef DMEM_BYTE_EN_EN
    be_d  = be_q;
`endif
    if (accept) begin
      a_d   = a;
      we_d  = we;
      wd_d  = wd;
      cnt_d = CNT_W'(LATENCY - 1);
`ifdef DMEM_BYTE_EN_EN
      be_d  = be;
`endif
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (commit) begin
      err_d = addr_err;
      if (addr_err)   rd_d = '0;
      else if (!we_q) rd_d = mem_rdata;
    end
  end

  assign rd  = rd_q;
  assign err = err_q;

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Bench for wait_state_data_memory: vector table of single accesses, plus
// back-to-back, reset-in-WAIT and (with DMEM_BYTE_EN_EN) byte-enable sequences.
module tb_wait_state_data_memory;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be = 4'hF;
`endif
  logic        ready, resp_valid, err;
  logic [31:0] rd;

  exp_t sbq[$];
  vec_t vt[15];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wait_state_data_memory #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .a          (a),
    .wd         (wd),
`ifdef DMEM_BYTE_EN_EN
    .be         (be),
`endif
    .ready      (ready),
    .resp_valid (resp_valid),
    .rd         (rd),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Compare the current response against the oldest scoreboard entry.
  task automatic pop_compare(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_sb_empty: got response want none", tag);
    end else begin
      e = sbq.pop_front();
      check({tag, "_rd"}, rd, e.rd);
      check({tag, "_err"}, 32'(err), 32'(e.err));
    end
  endtask

  // One isolated access: drive at negedge, check latency, ready, rd, err.
  task automatic access(input string tag, input bit w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; a = addr; wd = data;
    e.rd = exp_rd; e.err = exp_err;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // scramble request inputs: the block must use its latched copy
    req = 1'b0; we = ~w; a = $urandom; wd = $urandom;
    n = 1; seen = 1'b0;
    while (!seen && n <= 20) begin
      if (resp_valid) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        pop_compare(tag);
      end else begin
        if (n <= LAT) check({tag, "_ready_wait"}, 32'(ready), 32'd0);
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no resp_valid want resp_valid", tag);
    end
  endtask

  initial begin
    static logic [31:0] b2b_addr[3] = '{32'h0, 32'h4, 32'h8};
    static logic [31:0] b2b_data[3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    exp_t e;
    int   idx, got, cyc, last;

    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0,   32'h11111111, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b1, 32'h4,   32'h22222222, 32'hDEADBEEF, 1'b0};
    vt[4]  = '{1'b1, 32'h8,   32'h33333333, 32'hDEADBEEF, 1'b0};
    vt[5]  = '{1'b1, 32'hFC,  32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    vt[6]  = '{1'b0, 32'h4,   32'h0,        32'h22222222, 1'b0};
    vt[7]  = '{1'b1, 32'h102, 32'hCAFEF00D, 32'h00000000, 1'b1};
    vt[8]  = '{1'b1, 32'h100, 32'hCAFEF00D, 32'h00000000, 1'b1};
    vt[9]  = '{1'b0, 32'h0,   32'h0,        32'h11111111, 1'b0};
    vt[10] = '{1'b0, 32'hFC,  32'h0,        32'h0BADF00D, 1'b0};
    vt[11] = '{1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1};
    vt[12] = '{1'b0, 32'h3,   32'h0,        32'h00000000, 1'b1};
    vt[13] = '{1'b1, 32'h20,  32'h5A5A5A5A, 32'h00000000, 1'b0};
    vt[14] = '{1'b0, 32'h20,  32'h0,        32'h5A5A5A5A, 1'b0};

    // reset for 3 cycles, then idle outputs
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rd", rd, 32'h0);
    check("rst_err", 32'(err), 32'd0);

    for (int i = 0; i < 15; i++)
      access($sformatf("vec%0d", i), vt[i].we, vt[i].a, vt[i].wd, vt[i].exp_rd, vt[i].exp_err);

    // back-to-back reads with req held high; accepts land in RESP cycles
    @(negedge clk);
    req = 1'b1; we = 1'b0; a = b2b_addr[0];
    e.rd = b2b_data[0]; e.err = 1'b0; sbq.push_back(e);
    idx = 1; got = 0; cyc = 0; last = 0;
    while (got < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        pop_compare($sformatf("b2b%0d", got));
        check($sformatf("b2b%0d_spacing", got), 32'(cyc - last), 32'(LAT + 1));
        last = cyc;
        got++;
        if (idx < 3) begin
          a = b2b_addr[idx];
          e.rd = b2b_data[idx]; e.err = 1'b0; sbq.push_back(e);
          idx++;
        end else begin
          req = 1'b0;
        end
      end else begin
        check($sformatf("b2b_ready_wait%0d", cyc), 32'(ready), 32'd0);
      end
    end
    if (got < 3) begin
      total++; bad++;
      $display("FAIL b2b_timeout: got %0d responses want 3", got);
    end

    // reset pulsed during WAIT of a write to 0x20
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("midwait_in_wait", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_ready", 32'(ready), 32'd1);
    check("midwait_rst_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check($sformatf("midwait_no_resp%0d", i), 32'(resp_valid), 32'd0);
    end
    access("midwait_read", 1'b0, 32'h20, 32'h0, 32'h5A5A5A5A, 1'b0);

`ifdef DMEM_BYTE_EN_EN
    be = 4'hF;
    access("be_preload", 1'b1, 32'h30, 32'hAABBCCDD, 32'h5A5A5A5A, 1'b0);
    be = 4'b0101;
    access("be_0101_wr", 1'b1, 32'h30, 32'h11223344, 32'h5A5A5A5A, 1'b0);
    be = 4'hF;
    access("be_0101_rd", 1'b0, 32'h30, 32'h0, 32'hAA22CC44, 1'b0);
    be = 4'b0000;
    access("be_0000_wr", 1'b1, 32'h30, 32'hFFFFFFFF, 32'hAA22CC44, 1'b0);
    access("be_0000_rd", 1'b0, 32'h30, 32'h0, 32'hAA22CC44, 1'b0);
    be = 4'hF;
`endif

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
